// File: rtl/johnson_arb_ctrl_if.sv
// Request/grant bundle for johnson_arb_ctrl: requests and burst lengths in,
// one-hot grant, Johnson phase and status out.
interface johnson_arb_ctrl_if;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [3:0] phase;
    logic       step;
    logic       busy;
    logic       done;

    modport master (
        output req, len0, len1,
        input  gnt, phase, step, busy, done
    );

    modport slave (
        input  req, len0, len1,
        output gnt, phase, step, busy, done
    );
endinterface

// File: rtl/johnson_arb_ctrl.sv
// Two-requester round-robin burst controller stepping a 4-bit Johnson phase.
// Build option: define JOHNSON_PHASE_RESTART_EN to restart the phase at 0 on every grant.
module johnson_arb_ctrl (
    input  logic              clk,
    input  logic              rst,
    johnson_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] gnt_q;
    logic [3:0] phase_q;
    logic [3:0] cnt;
    logic       ptr;
    logic       step_q;
    logic       busy_q;
    logic       done_q;

    logic       win;
    logic       owner_req;

    // Any code outside the eight-state Johnson ring falls back to 0.
    function automatic logic [3:0] johnson_next(input logic [3:0] x);
        logic [3:0] nxt;
        case (x)
            4'd0, 4'd8, 4'd12, 4'd14,
            4'd15, 4'd7, 4'd3, 4'd1: nxt = {~x[0], x[3:1]};
            default:                 nxt = '0;
        endcase
        return nxt;
    endfunction

    always_comb begin
        win       = 1'b0;
        owner_req = 1'b0;
        if (bus.req == 2'b11)
            win = ptr;
        else
            win = bus.req[1];
        owner_req = |(gnt_q & bus.req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            phase_q <= '0;
            cnt     <= '0;
            ptr     <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= RUN;
                        gnt_q  <= win ? 2'b10 : 2'b01;
                        cnt    <= win ? bus.len1 : bus.len0;
                        ptr    <= ~win;
                        step_q <= 1'b1;
                        busy_q <= 1'b1;
`ifdef JOHNSON_PHASE_RESTART_EN
                        phase_q <= '0;
`else
                        phase_q <= phase_q;
`endif
                    end
                end
                RUN: begin
                    // Owner dropping its request aborts without advancing the phase.
                    if (!owner_req) begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        step_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        phase_q <= johnson_next(phase_q);
                        if (cnt == 4'd0) begin
                            state  <= DONE;
                            gnt_q  <= '0;
                            step_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    step_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.phase = phase_q;
    assign bus.step  = step_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_johnson_arb_ctrl.sv
// Self-checking bench for johnson_arb_ctrl against a burst-level reference model
// (phase tracked as a position in the Johnson sequence, pointer as a requester index).
module tb_johnson_arb_ctrl;

`ifdef JOHNSON_PHASE_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic clk;
    logic rst;
    johnson_arb_ctrl_if bus ();

    johnson_arb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: favoured requester and position in the phase sequence.
    int unsigned m_ptr = 0;
    int unsigned m_idx = 0;

    function automatic logic [3:0] jseq(input int unsigned i);
        logic [3:0] v;
        case (i % 8)
            0: v = 4'd0;
            1: v = 4'd8;
            2: v = 4'd12;
            3: v = 4'd14;
            4: v = 4'd15;
            5: v = 4'd7;
            6: v = 4'd3;
            default: v = 4'd1;
        endcase
        return v;
    endfunction

    function automatic logic [8:0] observed();
        return {bus.gnt, bus.phase, bus.step, bus.busy, bus.done};
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_idx = 0;
    endtask

    // Called at a negedge with the DUT in IDLE; runs one full burst and its trailing IDLE cycle.
    task automatic run_burst(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                             input bit keep, input string tag);
        int unsigned w, n, s;
        logic [8:0] exp_v, act;
        bus.req  = r;
        bus.len0 = l0;
        bus.len1 = l1;
        w     = (r == 2'b11) ? m_ptr : (r[1] ? 1 : 0);
        m_ptr = 1 - w;
        n     = (w == 1) ? (int'(l1) + 1) : (int'(l0) + 1);
        s     = RESTART ? 0 : m_idx;
        for (int k = 0; k < int'(n); k++) begin
            @(negedge clk);
            exp_v = {2'(1 << w), jseq(s + k), 1'b1, 1'b1, 1'b0};
            act   = observed();
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s run[%0d]: got {gnt,phase,step,busy,done}=%h, expected %h",
                         tag, k, act, exp_v);
            end
            bus.len0 = 4'($urandom);
            bus.len1 = 4'($urandom);
        end
        @(negedge clk);
        exp_v = {2'b00, jseq(s + n), 1'b0, 1'b1, 1'b1};
        act   = observed();
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s done: got %h, expected %h", tag, act, exp_v);
        end
        m_idx = (s + n) % 8;
        if (!keep) bus.req = 2'b00;
        @(negedge clk);
        exp_v = {2'b00, jseq(m_idx), 1'b0, 1'b0, 1'b0};
        act   = observed();
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s idle: got %h, expected %h", tag, act, exp_v);
        end
    endtask

    task automatic test_reset();
        logic [8:0] act;
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        repeat (2) @(negedge clk);
        act = observed();
        n_tests++;
        if (act !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, expected %h", act, 9'd0);
        end
        rst = 1'b0;
        // No request: the controller must sit in IDLE.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            act = observed();
            n_tests++;
            if (act !== 9'd0) begin
                n_fail++;
                $display("FAIL idle_no_req[%0d]: got %h, expected %h", k, act, 9'd0);
            end
        end
    endtask

    task automatic test_basic();
        run_burst(2'b01, 4'd2, 4'd0, 1'b0, "basic_len2");
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_burst(2'b11, 4'd1, 4'd2, 1'b1, "tie_first");
        run_burst(2'b11, 4'd0, 4'd1, 1'b1, "tie_second");
        run_burst(2'b11, 4'd3, 4'd0, 1'b0, "tie_third");
        run_burst(2'b10, 4'd0, 4'd0, 1'b0, "single_r1");
        run_burst(2'b10, 4'd1, 4'd0, 1'b0, "single_r1_again");
    endtask

    task automatic test_long();
        do_reset();
        run_burst(2'b10, 4'd0, 4'd15, 1'b0, "long_len15");
    endtask

    task automatic test_abort();
        logic [8:0] exp_v, act;
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 4'd7;
        bus.len1 = 4'd0;
        m_ptr    = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_v = {2'b01, jseq(k), 1'b1, 1'b1, 1'b0};
            act   = observed();
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL abort_run[%0d]: got %h, expected %h", k, act, exp_v);
            end
        end
        bus.req = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_v = {2'b00, 4'd12, 1'b0, 1'b0, 1'b0};
            act   = observed();
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL abort_after[%0d]: got %h, expected %h", k, act, exp_v);
            end
        end
        m_idx = 2;
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp_v, act;
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 4'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_v = {2'b01, jseq(k), 1'b1, 1'b1, 1'b0};
            act   = observed();
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_run[%0d]: got %h, expected %h", k, act, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        act = observed();
        n_tests++;
        if (act !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h, expected %h", act, 9'd0);
        end
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_idx = 0;
        run_burst(2'b11, 4'd1, 4'd1, 1'b0, "rstmid_regrant");
    endtask

    task automatic test_phase_continuity();
        do_reset();
        run_burst(2'b01, 4'd1, 4'd0, 1'b0, "cont_first");
        run_burst(2'b01, 4'd1, 4'd0, 1'b0, "cont_second");
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int i = 0; i < 25; i++) begin
            r = 2'($urandom_range(1, 3));
            run_burst(r, 4'($urandom), 4'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_long();
        test_abort();
        test_reset_mid();
        test_phase_continuity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
